// File: rtl/cost_func_unit.sv
// Squared-error cost unit for a single perceptron output.
// A rising edge on dataReady captures the pre-activation and the target bit,
// then a fixed five-state sequence evaluates a piecewise-linear sigmoid,
// squares the error against the target, and announces the result with a
// one-cycle newCostFunc pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a dataReady rising edge; sample captured on it
//   SIG   | sigmoid approximation of the captured sample is registered
//   SQR   | squared error registered onto costFunc
//   HOLD  | raises newCostFunc for the following cycle
//   PULSE | newCostFunc high; returns to IDLE
module cost_func_unit #(
  parameter  int QN       = 6,
  parameter  int QM       = 11,
  localparam int BITWIDTH = QN + QM + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dataReady,
  input  logic [BITWIDTH-1:0] networkOutput,
  input  logic                target,
  output logic [BITWIDTH-1:0] costFunc,
  output logic                newCostFunc,
  output logic                busy,
  output logic                dropped
);

  // sigmoid values live in [0, 1.0], error in [-1.0, 1.0]
  localparam int YW    = QM + 1;
  localparam int EW    = QM + 2;
  localparam int ONE_I = 1 << QM;

  // segment breakpoints on |x|: 5.0, 2.375, 1.0
  localparam logic [BITWIDTH-1:0] TH_SAT = BITWIDTH'(5 * ONE_I);
  localparam logic [BITWIDTH-1:0] TH_MID = BITWIDTH'((19 * ONE_I) / 8);
  localparam logic [BITWIDTH-1:0] TH_LOW = BITWIDTH'(ONE_I);

  // segment offsets: 0.84375, 0.625, 0.5 (exact because QM >= 5)
  localparam logic [YW-1:0] ONE_Y   = YW'(ONE_I);
  localparam logic [YW-1:0] OFS_HI  = YW'(27 << (QM - 5));
  localparam logic [YW-1:0] OFS_MID = YW'(5 << (QM - 3));
  localparam logic [YW-1:0] OFS_LOW = YW'(1 << (QM - 1));

  typedef enum logic [2:0] {
    IDLE,
    SIG,
    SQR,
    HOLD,
    PULSE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                  dr_q;
  logic                  trigger;
  logic [BITWIDTH-1:0]   x_q;
  logic                  t_q;
  logic [YW-1:0]         y_q;

  logic [BITWIDTH-1:0]   a_abs;
  logic [YW-1:0]         y_pos;
  logic [YW-1:0]         y_next;
  logic signed [EW-1:0]  err;
  logic signed [2*EW-1:0] sq;

  assign trigger = dataReady & ~dr_q;
  assign busy    = (state_q != IDLE);

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state: only IDLE waits, every other state advances unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger) state_d = SIG;
      SIG:     state_d = SQR;
      SQR:     state_d = HOLD;
      HOLD:    state_d = PULSE;
      PULSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // piecewise-linear sigmoid on the magnitude, mirrored for negative inputs;
  // the magnitude is kept combinational since only y is needed downstream
  always_comb begin
    a_abs = x_q[BITWIDTH-1] ? -x_q : x_q;
    y_pos = OFS_LOW;
    if (a_abs >= TH_SAT) begin
      y_pos = ONE_Y;
    end else if (a_abs >= TH_MID) begin
      y_pos = YW'(a_abs >> 5) + OFS_HI;
    end else if (a_abs >= TH_LOW) begin
      y_pos = YW'(a_abs >> 3) + OFS_MID;
    end else begin
      y_pos = YW'(a_abs >> 2) + OFS_LOW;
    end
    y_next = x_q[BITWIDTH-1] ? (ONE_Y - y_pos) : y_pos;
  end

  // error against the target level and its square
  always_comb begin
    err = $signed({1'b0, t_q, {QM{1'b0}}}) - $signed({1'b0, y_q});
    sq  = err * err;
  end

  // datapath registers, edge detector and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      dr_q        <= 1'b1;
      x_q         <= '0;
      t_q         <= 1'b0;
      y_q         <= '0;
      costFunc    <= '0;
      newCostFunc <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      dr_q <= dataReady;
      if (state_q == IDLE && trigger) begin
        x_q <= networkOutput;
        t_q <= target;
      end
      if (state_q == SIG) begin
        y_q <= y_next;
      end
      if (state_q == SQR) begin
        costFunc <= BITWIDTH'(sq >> QM);
      end
      newCostFunc <= (state_q == HOLD);
      if (trigger && state_q != IDLE) begin
        dropped <= 1'b1;
      end
    end
  end

endmodule
